// File: rtl/decoder_stage_sequencer.sv
// decoder_stage_sequencer
// Sequences the union-find decoder array through a decode. It accepts a syndrome,
// clears the array, and repeats GROW -> SPREAD -> SYNC -> CHECK until no odd
// cluster remains. The SPREAD and SYNC phases end when the array stops sending
// messages, not after a fixed delay. The block then reports the iteration count
// and whether the decode timed out.
// Every output is registered from the next-state value. As a result, stage and
// the flags change on the same edge that enters the state they belong to.
module decoder_stage_sequencer #(
   parameter int CODE_DISTANCE      = 3,
   parameter int MEASUREMENT_ROUNDS = 1,
   parameter int PU_COUNT           = CODE_DISTANCE*(CODE_DISTANCE-1)*MEASUREMENT_ROUNDS,
   parameter int MAX_ITERATIONS     = 2*CODE_DISTANCE,
   parameter int MIN_PHASE_CYCLES   = 4,
   parameter int QUIET_CYCLES       = 2,
   parameter int PHASE_TIMEOUT      = 64,
   parameter int ITER_WIDTH         = $clog2(MAX_ITERATIONS+1),
   parameter int STAGE_WIDTH        = 3,
   parameter logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0,
   parameter logic [STAGE_WIDTH-1:0] STAGE_SPREAD_CLUSTER      = 3'd1,
   parameter logic [STAGE_WIDTH-1:0] STAGE_GROW_BOUNDARY       = 3'd2,
   parameter logic [STAGE_WIDTH-1:0] STAGE_SYNC_IS_ODD_CLUSTER = 3'd3
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   syndrome_valid,
   output logic                   syndrome_ready,
   input  logic [PU_COUNT-1:0]    syndrome_in,
   input  logic                   abort,
   output logic [STAGE_WIDTH-1:0] stage,
   output logic                   array_reset,
   output logic [PU_COUNT-1:0]    is_error_syndromes,
   input  logic                   has_message_flying,
   input  logic [PU_COUNT-1:0]    is_odd_clusters,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic [ITER_WIDTH-1:0]  iteration_count,
   output logic                   timeout
);

   // Counter widths carry one spare value so that n_cur and q_cur never wrap.
   localparam int PW = $clog2(PHASE_TIMEOUT+2);
   localparam int QW = $clog2(QUIET_CYCLES+2);

   // FLUSH is the one-cycle array clear used by abort before the FSM returns to IDLE.
   typedef enum logic [3:0] {
      IDLE, CLEAR, SETTLE, GROW, SPREAD, SYNC, CHECK, DONE, FLUSH
   } state_t;

   state_t                  state_reg, state_next;
   logic [PW-1:0]           phase_cnt_reg, phase_cnt_next, n_cur;
   logic [QW-1:0]           quiet_cnt_reg, quiet_cnt_next, q_cur;
   logic                    phase_exit, phase_expired;
   logic [ITER_WIDTH-1:0]   iter_next;
   logic                    timeout_next;
   logic [PU_COUNT-1:0]     syn_next;
   logic [STAGE_WIDTH-1:0]  stage_next;

   // Phase bookkeeping for the current cycle: the cycles spent in the phase and
   // the run of quiet samples. Both values include the sample taken this cycle.
   always_comb begin
      n_cur = phase_cnt_reg + PW'(1);
      if (has_message_flying)
         q_cur = '0;
      else if (quiet_cnt_reg >= QW'(QUIET_CYCLES))
         q_cur = quiet_cnt_reg;
      else
         q_cur = quiet_cnt_reg + QW'(1);
      phase_exit    = (n_cur >= PW'(MIN_PHASE_CYCLES)) && (q_cur >= QW'(QUIET_CYCLES));
      phase_expired = (n_cur >= PW'(PHASE_TIMEOUT));
   end

   // Next state and next register values. Abort is evaluated last so that it
   // overrides every other transition.
   always_comb begin
      state_next     = state_reg;
      iter_next      = iteration_count;
      timeout_next   = timeout;
      syn_next       = is_error_syndromes;
      phase_cnt_next = '0;
      quiet_cnt_next = '0;
      case (state_reg)
         IDLE: begin
            if (syndrome_valid) begin
               syn_next     = syndrome_in;
               iter_next    = '0;
               timeout_next = 1'b0;
               state_next   = CLEAR;
            end
         end
         CLEAR:  state_next = SETTLE;
         SETTLE: begin
            if (is_error_syndromes == '0) begin
               state_next = DONE;
            end else begin
               state_next = GROW;
               iter_next  = iteration_count + ITER_WIDTH'(1);
            end
         end
         GROW:   state_next = SPREAD;
         SPREAD, SYNC: begin
            if (phase_exit) begin
               state_next = (state_reg == SPREAD) ? SYNC : CHECK;
            end else if (phase_expired) begin
               timeout_next = 1'b1;
               state_next   = DONE;
            end else begin
               phase_cnt_next = n_cur;
               quiet_cnt_next = q_cur;
            end
         end
         CHECK: begin
            if (is_odd_clusters == '0) begin
               timeout_next = 1'b0;
               state_next   = DONE;
            end else if (iteration_count == ITER_WIDTH'(MAX_ITERATIONS)) begin
               timeout_next = 1'b1;
               state_next   = DONE;
            end else begin
               iter_next  = iteration_count + ITER_WIDTH'(1);
               state_next = GROW;
            end
         end
         DONE:    if (result_ready) state_next = IDLE;
         FLUSH:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (abort && state_reg != IDLE && state_reg != DONE && state_reg != FLUSH) begin
         state_next     = FLUSH;
         timeout_next   = 1'b0;
         iter_next      = iteration_count;
         phase_cnt_next = '0;
         quiet_cnt_next = '0;
      end
   end

   // Stage value that the array sees during the state being entered.
   always_comb begin
      case (state_next)
         GROW:    stage_next = STAGE_GROW_BOUNDARY;
         SPREAD:  stage_next = STAGE_SPREAD_CLUSTER;
         SYNC:    stage_next = STAGE_SYNC_IS_ODD_CLUSTER;
         default: stage_next = STAGE_IDLE;
      endcase
   end

   // State, counters and all registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg          <= IDLE;
         phase_cnt_reg      <= '0;
         quiet_cnt_reg      <= '0;
         stage              <= STAGE_IDLE;
         array_reset        <= 1'b0;
         syndrome_ready     <= 1'b1;
         is_error_syndromes <= '0;
         result_valid       <= 1'b0;
         iteration_count    <= '0;
         timeout            <= 1'b0;
      end else begin
         state_reg          <= state_next;
         phase_cnt_reg      <= phase_cnt_next;
         quiet_cnt_reg      <= quiet_cnt_next;
         stage              <= stage_next;
         array_reset        <= (state_next == CLEAR) || (state_next == FLUSH);
         syndrome_ready     <= (state_next == IDLE);
         is_error_syndromes <= syn_next;
         result_valid       <= (state_next == DONE);
         iteration_count    <= iter_next;
         timeout            <= timeout_next;
      end
   end

endmodule

// File: tb/tb_decoder_stage_sequencer.sv
// Testbench for decoder_stage_sequencer. The array is replaced by a stub:
//  - has_message_flying comes from a per-cycle pattern;
//  - is_odd_clusters stays nonzero until a chosen number of GROW phases has been seen.
// The expected results come from a hand table and from a phase-level reference model.
module tb_decoder_stage_sequencer;

   localparam int PU   = 6;
   localparam int PU2  = 12;
   localparam int MAXI = 6;
   localparam int MINP = 4;
   localparam int QC   = 2;
   localparam int PT   = 64;
   localparam logic [2:0] ST_IDLE = 3'd0, ST_SPREAD = 3'd1, ST_GROW = 3'd2, ST_SYNC = 3'd3;

   logic clk, reset_n;
   logic syndrome_valid, syndrome_ready, abort, array_reset, has_message_flying;
   logic result_valid, result_ready, timeout;
   logic [PU-1:0] syndrome_in, is_error_syndromes, is_odd_clusters;
   logic [2:0] stage, iteration_count;

   logic syndrome_valid_b, syndrome_ready_b, array_reset_b, result_valid_b, result_ready_b, timeout_b;
   logic [PU2-1:0] syndrome_in_b, is_error_syndromes_b;
   logic [2:0] stage_b, iteration_count_b;

   int errors = 0;
   int checks = 0;
   bit fly_arr [0:2047];

   decoder_stage_sequencer dut (
      .clk(clk), .reset_n(reset_n), .syndrome_valid(syndrome_valid), .syndrome_ready(syndrome_ready),
      .syndrome_in(syndrome_in), .abort(abort), .stage(stage), .array_reset(array_reset),
      .is_error_syndromes(is_error_syndromes), .has_message_flying(has_message_flying),
      .is_odd_clusters(is_odd_clusters), .result_valid(result_valid), .result_ready(result_ready),
      .iteration_count(iteration_count), .timeout(timeout));

   decoder_stage_sequencer #(.MEASUREMENT_ROUNDS(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .syndrome_valid(syndrome_valid_b), .syndrome_ready(syndrome_ready_b),
      .syndrome_in(syndrome_in_b), .abort(1'b0), .stage(stage_b), .array_reset(array_reset_b),
      .is_error_syndromes(is_error_syndromes_b), .has_message_flying(1'b0),
      .is_odd_clusters(12'd0), .result_valid(result_valid_b), .result_ready(result_ready_b),
      .iteration_count(iteration_count_b), .timeout(timeout_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Flying pattern: mode 0 = always quiet, 1 = stuck busy, 2 = random table.
   function automatic bit fly_at(input int mode, input int c);
      if (mode == 0) return 1'b0;
      if (mode == 1) return 1'b1;
      return (c < 2048) ? fly_arr[c] : 1'b0;
   endfunction

   // Reference: length of a SPREAD/SYNC phase starting at cycle 'start'.
   // The result is positive if the phase ends on quiescence and negative if it times out.
   function automatic int phase_len(input int start, input int mode);
      int n, q;
      n = 0; q = 0;
      for (int c = start; c < start + PT + 1; c++) begin
         n++;
         q = fly_at(mode, c) ? 0 : q + 1;
         if (n >= MINP && q >= QC) return n;
         if (n >= PT) return -n;
      end
      return -n;
   endfunction

   // Reference decode model. It works phase by phase. Cycle 1 is the first cycle
   // after the accepting edge.
   task automatic model_run(input logic [PU-1:0] syn, input int k_odd, input int mode,
                            output int done_c, output int iter, output int to, output int sp, output int sy);
      int c, res;
      iter = 0; to = 0; sp = 0; sy = 0; done_c = 3;
      if (syn != '0) begin
         c = 3;
         forever begin
            iter++;
            res = phase_len(c + 1, mode);
            if (res < 0) begin sp += -res; to = 1; done_c = c + 1 - res; break; end
            sp += res; c = c + 1 + res;
            res = phase_len(c, mode);
            if (res < 0) begin sy += -res; to = 1; done_c = c - res; break; end
            sy += res; c = c + res;
            if (iter >= k_odd) begin done_c = c + 1; break; end
            if (iter == MAXI) begin to = 1; done_c = c + 1; break; end
            c = c + 1;
         end
      end
   endtask

   task automatic run_decode(input logic [PU-1:0] syn, input int k_odd, input int mode, input int hold,
                             input int e_done, input int e_iter, input int e_to, input int e_sp, input int e_sy);
      int done_c, grows, sp, sy;
      syndrome_in = syn; syndrome_valid = 1'b1;
      @(posedge clk);
      done_c = -1; grows = 0; sp = 0; sy = 0;
      for (int c = 1; c < 1500; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("clear_pulse", array_reset, 1);
            chk("ready_low", syndrome_ready, 0);
            syndrome_in = ~syn;             // offered while busy: must not be latched
         end
         if (c == 2) begin
            chk("clear_len", array_reset, 0);
            syndrome_valid = 1'b0;
         end
         if (result_valid) begin done_c = c; break; end
         if (stage == ST_GROW) grows++;
         if (stage == ST_SPREAD) sp++;
         if (stage == ST_SYNC) sy++;
         has_message_flying = fly_at(mode, c);
         is_odd_clusters = (grows < k_odd) ? PU'($urandom_range(1, 63)) : '0;
      end
      syndrome_valid = 1'b0;
      chk("latency", done_c, e_done);
      chk("iteration_count", iteration_count, e_iter);
      chk("timeout", timeout, e_to);
      chk("grow_phases", grows, e_iter);
      chk("spread_cycles", sp, e_sp);
      chk("sync_cycles", sy, e_sy);
      chk("done_stage", stage, ST_IDLE);
      chk("done_syndromes", is_error_syndromes, syn);
      chk("done_ready", syndrome_ready, 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", result_valid, 1);
         chk("hold_iter", iteration_count, e_iter);
         chk("hold_timeout", timeout, e_to);
      end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      chk("valid_drop", result_valid, 0);
      chk("ready_rise", syndrome_ready, 1);
      chk("syndromes_held", is_error_syndromes, syn);
      has_message_flying = 1'b0; is_odd_clusters = '0;
      $display("txn syn=%h k=%0d mode=%0d latency=%0d/%0d iter=%0d/%0d timeout=%0d/%0d",
               syn, k_odd, mode, done_c, e_done, iteration_count, e_iter, timeout, e_to);
   endtask

   typedef struct {
      logic [PU-1:0] syn;
      int k_odd, mode, hold, e_done, e_iter, e_to, e_sp, e_sy;
   } vec_t;
   vec_t vecs [5];

   initial begin
      int c, e_done, e_iter, e_to, e_sp, e_sy, k;
      logic [PU-1:0] syn;
      vecs[0] = '{6'b000000, 0, 0, 2,  3, 0, 0,  0,  0};   // zero syndrome
      vecs[1] = '{6'b001100, 1, 0, 1, 13, 1, 0,  4,  4};   // (1,0),(1,1): one iteration
      vecs[2] = '{6'b000100, 2, 0, 0, 23, 2, 0,  8,  8};   // (1,0) alone: two iterations
      vecs[3] = '{6'b100001, 7, 1, 3, 68, 1, 1, 64,  0};   // messages never settle
      vecs[4] = '{6'b010010, 7, 0, 5, 63, 6, 1, 24, 24};   // odd clusters never vanish

      reset_n = 1'b0; syndrome_valid = 1'b0; syndrome_in = '0; abort = 1'b0;
      has_message_flying = 1'b0; is_odd_clusters = '0; result_ready = 1'b0;
      syndrome_valid_b = 1'b0; syndrome_in_b = '0; result_ready_b = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_stage", stage, ST_IDLE);
      chk("rst_array_reset", array_reset, 0);
      chk("rst_ready", syndrome_ready, 1);
      chk("rst_syndromes", is_error_syndromes, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_iter", iteration_count, 0);
      chk("rst_timeout", timeout, 0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", syndrome_ready, 1);

      foreach (vecs[i])
         run_decode(vecs[i].syn, vecs[i].k_odd, vecs[i].mode, vecs[i].hold,
                    vecs[i].e_done, vecs[i].e_iter, vecs[i].e_to, vecs[i].e_sp, vecs[i].e_sy);

      // Abort in the last SPREAD cycle, where the phase would also exit: abort wins.
      syndrome_in = 6'b010000; syndrome_valid = 1'b1;
      @(posedge clk);
      for (c = 1; c <= 7; c++) begin
         @(negedge clk);
         syndrome_valid = 1'b0; has_message_flying = 1'b0; is_odd_clusters = 6'b000001;
      end
      chk("abort_in_spread", stage, ST_SPREAD);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_flush", array_reset, 1);
      chk("abort_stage", stage, ST_IDLE);
      chk("abort_no_valid", result_valid, 0);
      @(negedge clk);
      chk("abort_idle_ready", syndrome_ready, 1);
      chk("abort_flush_len", array_reset, 0);
      chk("abort_timeout", timeout, 0);
      repeat (3) @(negedge clk);
      chk("abort_still_no_valid", result_valid, 0);
      is_odd_clusters = '0;
      $display("txn abort during SPREAD: array_reset pulse then IDLE");

      // Asynchronous reset in the middle of SYNC.
      syndrome_in = 6'b000100; syndrome_valid = 1'b1;
      @(posedge clk);
      for (c = 1; c <= 9; c++) begin
         @(negedge clk);
         syndrome_valid = 1'b0; has_message_flying = 1'b0; is_odd_clusters = 6'b000001;
      end
      chk("pre_reset_sync", stage, ST_SYNC);
      reset_n = 1'b0;
      #1;
      chk("arst_stage", stage, ST_IDLE);
      chk("arst_ready", syndrome_ready, 1);
      chk("arst_syndromes", is_error_syndromes, 0);
      chk("arst_iter", iteration_count, 0);
      chk("arst_array_reset", array_reset, 0);
      chk("arst_valid", result_valid, 0);
      chk("arst_timeout", timeout, 0);
      is_odd_clusters = '0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      $display("txn reset_n pulsed mid-SYNC");
      run_decode(6'b000000, 0, 0, 0, 3, 0, 0, 0, 0);

      // Two measurement rounds (12 syndrome bits), all zero.
      syndrome_in_b = '0; syndrome_valid_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      syndrome_valid_b = 1'b0;
      c = 1;
      while (!result_valid_b && c < 20) begin
         if (stage_b != ST_IDLE) chk("mr2_stage_idle", stage_b, ST_IDLE);
         @(negedge clk);
         c++;
      end
      chk("mr2_latency", c, 3);
      chk("mr2_iter", iteration_count_b, 0);
      chk("mr2_timeout", timeout_b, 0);
      result_ready_b = 1'b1;
      @(negedge clk);
      result_ready_b = 1'b0;
      chk("mr2_valid_drop", result_valid_b, 0);
      $display("txn MEASUREMENT_ROUNDS=2 zero syndrome latency=%0d", c);

      // Randomised decodes checked against the phase-level model.
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < 2048; i++) fly_arr[i] = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 4) == 0) begin
            c = $urandom_range(4, 200);
            for (int i = 0; i < 70; i++) fly_arr[c + i] = 1'b1;
         end
         syn = ($urandom_range(0, 5) == 0) ? '0 : PU'($urandom_range(1, 63));
         k = $urandom_range(1, 7);
         model_run(syn, k, 2, e_done, e_iter, e_to, e_sp, e_sy);
         run_decode(syn, k, 2, $urandom_range(0, 3), e_done, e_iter, e_to, e_sp, e_sy);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
